// File: rtl/dot_product_engine.sv
// dot_product_engine: streaming VEC_LEN-element dot product with a two-stage multiply/accumulate pipeline
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      begins a vector from IDLE (clears accumulator, count and sticky overflow)
//   in_valid   A/B carry a valid element pair
//   in_ready   engine takes a pair this cycle (ACCUM only, until VEC_LEN pairs are in)
//   A, B       operand elements (unsigned or two's complement per SIGNED)
//   out_valid  result/oflow valid, held until out_ready
//   out_ready  sink consumes the result
//   result     dot product after the overflow policy (zero or saturate per SAT)
//   oflow      accumulator left the OUT_W range at some point in the vector
//   busy       engine is in ACCUM, DRAIN or DONE
module dot_product_engine #(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16,
    parameter int SIGNED  = 0,
    parameter int SAT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  result,
    output logic              oflow,
    output logic              busy
);
    localparam int PW = 2 * DATA_W;
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       count;
    logic [PW-1:0]       prod;
    logic                prod_valid;
    logic [ACC_W-1:0]    acc;
    logic                sticky;
    logic signed [PW-1:0] mul_s;
    logic [PW-1:0]       mul_u;
    logic [PW-1:0]       mul;
    logic [ACC_W-1:0]    acc_next;
    logic                oflow_next;
    logic [OUT_W-1:0]    res_next;
    logic                accept;

    assign accept = in_valid & in_ready;
    assign busy   = state != IDLE;
    assign mul_s  = PW'($signed(A)) * PW'($signed(B));
    assign mul_u  = PW'(A) * PW'(B);
    assign mul    = SIGNED != 0 ? mul_s : mul_u;

    // product is sign- or zero-extended before joining the accumulator
    assign acc_next = acc + {{(ACC_W-PW){SIGNED != 0 && prod[PW-1]}}, prod};

    // signed range holds iff bits [ACC_W-1:OUT_W-1] are all copies of the sign
    assign oflow_next = sticky | (SIGNED != 0
        ? (acc_next[ACC_W-1:OUT_W-1] != '0 && acc_next[ACC_W-1:OUT_W-1] != '1)
        : acc_next[ACC_W-1:OUT_W] != '0);

    assign res_next = !oflow_next ? acc_next[OUT_W-1:0]
                    : SAT == 0    ? '0
                    : SIGNED == 0 ? '1
                    : acc_next[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                    : {1'b0, {(OUT_W-1){1'b1}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
            sticky     <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            result     <= '0;
            oflow      <= 1'b0;
        end else begin
            prod_valid <= accept;
            if (accept)
                prod <= mul;
            if (prod_valid) begin
                acc    <= acc_next;
                sticky <= oflow_next;
            end
            case (state)
                IDLE: if (start) begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                    count    <= '0;
                    acc      <= '0;
                    sticky   <= 1'b0;
                end
                ACCUM: if (accept) begin
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        in_ready <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                // the last product is accumulated on this edge, so result/oflow use the next values
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    result    <= res_next;
                    oflow     <= oflow_next;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: four engines (all SIGNED/SAT combinations) on shared stimulus, checked against an arithmetic model
module tb_dot_product_engine;
    logic        clk = 0;
    logic        rst = 0;
    logic        start = 0;
    logic        in_valid = 0;
    logic        out_ready = 0;
    logic [7:0]  A = 0;
    logic [7:0]  B = 0;
    logic        rdy [4];
    logic        ov  [4];
    logic        ofl [4];
    logic        bsy [4];
    logic [15:0] res [4];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dot_product_engine #(.SIGNED(g / 2), .SAT(g % 2)) u_dut (
            .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy[g]),
            .A(A), .B(B), .out_valid(ov[g]), .out_ready(out_ready),
            .result(res[g]), .oflow(ofl[g]), .busy(bsy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic void model(input logic [7:0] va [4], input logic [7:0] vb [4],
                                  input bit sgn, input bit sat, output logic [15:0] r, output bit o);
        longint s = 0;
        o = 0;
        for (int i = 0; i < 4; i++) begin
            if (sgn) s += longint'($signed(va[i])) * longint'($signed(vb[i]));
            else     s += longint'(va[i]) * longint'(vb[i]);
            if (sgn ? (s < -32768 || s > 32767) : (s > 65535)) o = 1;
        end
        r = !o ? 16'(s) : !sat ? 16'h0 : !sgn ? 16'hFFFF : (s < 0 ? 16'h8000 : 16'h7FFF);
    endfunction

    task automatic run_vec(input logic [7:0] va [4], input logic [7:0] vb [4],
                           input int gap_len, input int hold, input bit poke);
        int k = 0, cyc = 0, last = 0, gap = 0, lat;
        logic [15:0] er [4];
        bit eo [4];
        for (int i = 0; i < 4; i++) model(va, vb, i / 2, i % 2, er[i], eo[i]);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_accum", bsy[0], 1);
        while (k < 4 && cyc < 100) begin
            if (gap > 0) begin
                in_valid = 0;
                gap--;
            end else begin
                in_valid = 1;
                A = va[k];
                B = vb[k];
            end
            if (poke && cyc == 1) start = 1;
            if (in_valid && rdy[0]) begin
                k++;
                last = cyc;
                gap = gap_len;
            end
            @(negedge clk);
            start = 0;
            cyc++;
        end
        chk("accepts", k, 4);
        in_valid = 1;
        A = 8'hFF;
        B = 8'hFF;
        chk("ready_drain", rdy[0], 0);
        chk("valid_drain", ov[0], 0);
        lat = cyc - last;
        while (!ov[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 2);
        chk("ready_done", rdy[0], 0);
        chk("busy_done", bsy[0], 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("result%0d", i), res[i], er[i]);
            chk($sformatf("oflow%0d", i), ofl[i], eo[i]);
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 0;
            start = poke;
            @(negedge clk);
            start = 0;
            chk("hold_valid", ov[0], 1);
            chk("hold_result", res[0], er[0]);
        end
        out_ready = 1;
        start = poke;
        @(negedge clk);
        start = 0;
        out_ready = 0;
        in_valid = 0;
        chk("valid_drop", ov[0], 0);
        chk("busy_idle", bsy[0], 0);
        chk("result_keep", res[3], er[3]);
        chk("oflow_keep", ofl[3], eo[3]);
    endtask

    initial begin
        logic [7:0] va [4], vb [4];
        repeat (2) @(negedge clk);
        chk("rst_ready", rdy[0], 0);
        chk("rst_valid", ov[0], 0);
        chk("rst_result", res[0], 0);
        chk("rst_oflow", ofl[0], 0);
        chk("rst_busy", bsy[0], 0);
        rst = 1;
        @(negedge clk);

        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vb = '{8'd5, 8'd6, 8'd7, 8'd8};
        run_vec(va, vb, 0, 0, 0);
        chk("case1_70", res[0], 70);
        va = '{8'd255, 8'd255, 8'd255, 8'd255};
        run_vec(va, va, 0, 0, 0);
        chk("sat_ffff", res[1], 16'hFFFF);
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        run_vec(va, vb, 3, 5, 0);
        va = '{8'hFD, 8'hFD, 8'd100, 8'd0};
        vb = '{8'd4, 8'd4, 8'd1, 8'd0};
        run_vec(va, vb, 0, 1, 0);
        chk("signed_76", res[2], 16'h004C);
        va = '{8'h80, 8'h80, 8'h80, 8'h80};
        run_vec(va, va, 1, 0, 0);
        chk("signed_sat", res[3], 16'h7FFF);

        start = 1;
        @(negedge clk);
        start = 0;
        in_valid = 1;
        A = 1;
        B = 5;
        @(negedge clk);
        A = 2;
        B = 6;
        @(negedge clk);
        in_valid = 0;
        #2 rst = 0;
        #1;
        chk("mid_ready", rdy[0], 0);
        chk("mid_valid", ov[0], 0);
        chk("mid_result", res[3], 0);
        chk("mid_oflow", ofl[3], 0);
        chk("mid_busy", bsy[0], 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vb = '{8'd5, 8'd6, 8'd7, 8'd8};
        run_vec(va, vb, 0, 0, 0);
        chk("after_rst_70", res[0], 70);

        va = '{8'd255, 8'd255, 8'd255, 8'd255};
        run_vec(va, va, 1, 2, 1);
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        run_vec(va, vb, 0, 0, 1);
        chk("b2b_oflow", ofl[0], 0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 4; i++) begin
                va[i] = 8'($urandom);
                vb[i] = 8'($urandom);
            end
            run_vec(va, vb, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
